// File: rtl/subservient_sram_arbiter.sv
// Two 32-bit Wishbone-classic masters share one byte-wide synchronous SRAM.
// Each word access becomes four byte accesses with a fixed 5-cycle ack latency.
module subservient_sram_arbiter #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [aw-1:0] i_wb_cpu_adr,
  input  logic [31:0]   i_wb_cpu_dat,
  input  logic [3:0]    i_wb_cpu_sel,
  input  logic          i_wb_cpu_we,
  input  logic          i_wb_cpu_cyc,
  output logic [31:0]   o_wb_cpu_rdt,
  output logic          o_wb_cpu_ack,
  input  logic [aw-1:0] i_wb_dbg_adr,
  input  logic [31:0]   i_wb_dbg_dat,
  input  logic [3:0]    i_wb_dbg_sel,
  input  logic          i_wb_dbg_we,
  input  logic          i_wb_dbg_cyc,
  output logic [31:0]   o_wb_dbg_rdt,
  output logic          o_wb_dbg_ack,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE, ACK} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [aw-3:0] adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          last_dbg_q;  // last granted port; also owns the transfer in flight
  logic          rd_vld_q;
  logic [1:0]    rd_idx_q;
  logic [31:0]   rdt_q;
  logic          grant, grant_dbg;
  logic          unused_adr;

  assign unused_adr = ^{i_wb_cpu_adr[1:0], i_wb_dbg_adr[1:0]};

  assign grant     = i_wb_cpu_cyc | i_wb_dbg_cyc;
  assign grant_dbg = i_wb_dbg_cyc & (~i_wb_cpu_cyc | ~last_dbg_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = XFER;
        cnt_d   = 2'd0;
      end
      XFER: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      last_dbg_q <= 1'b1;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= 2'd0;
      rdt_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && grant) begin
        last_dbg_q <= grant_dbg;
        adr_q      <= grant_dbg ? i_wb_dbg_adr[aw-1:2] : i_wb_cpu_adr[aw-1:2];
        dat_q      <= grant_dbg ? i_wb_dbg_dat : i_wb_cpu_dat;
        sel_q      <= grant_dbg ? i_wb_dbg_sel : i_wb_cpu_sel;
        we_q       <= grant_dbg ? i_wb_dbg_we  : i_wb_cpu_we;
      end
      // SRAM data appears one cycle after the read is sampled, so delay the tag
      rd_vld_q <= (state_q == XFER) & ~we_q;
      rd_idx_q <= cnt_q;
      if (rd_vld_q) rdt_q[8*rd_idx_q +: 8] <= i_sram_rdata;
    end
  end

  assign o_sram_waddr = {adr_q, cnt_q};
  assign o_sram_raddr = {adr_q, cnt_q};
  assign o_sram_wdata = dat_q[8*cnt_q +: 8];
  assign o_sram_wen   = (state_q == XFER) & we_q & sel_q[cnt_q];
  assign o_sram_ren   = (state_q == XFER) & ~we_q;

  assign o_wb_cpu_ack = (state_q == ACK) & ~last_dbg_q;
  assign o_wb_dbg_ack = (state_q == ACK) &  last_dbg_q;
  assign o_wb_cpu_rdt = rdt_q;
  assign o_wb_dbg_rdt = rdt_q;

endmodule

// File: tb/tb_subservient_sram_arbiter.sv
// Directed bench for subservient_sram_arbiter with a behavioural byte SRAM.
module tb_subservient_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cpu_adr = '0, dbg_adr = '0;
  logic [31:0] cpu_dat = '0, dbg_dat = '0;
  logic [3:0]  cpu_sel = '0, dbg_sel = '0;
  logic        cpu_we = 1'b0, dbg_we = 1'b0;
  logic        cpu_cyc = 1'b0, dbg_cyc = 1'b0;
  logic [31:0] cpu_rdt, dbg_rdt;
  logic        cpu_ack, dbg_ack;
  logic [7:0]  waddr, raddr, wdata;
  logic        wen, ren;
  logic [7:0]  rdata = '0;
  logic [7:0]  mem [256] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subservient_sram_arbiter #(.depth(256)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat), .i_wb_cpu_sel(cpu_sel),
    .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
    .o_wb_cpu_rdt(cpu_rdt), .o_wb_cpu_ack(cpu_ack),
    .i_wb_dbg_adr(dbg_adr), .i_wb_dbg_dat(dbg_dat), .i_wb_dbg_sel(dbg_sel),
    .i_wb_dbg_we(dbg_we), .i_wb_dbg_cyc(dbg_cyc),
    .o_wb_dbg_rdt(dbg_rdt), .o_wb_dbg_ack(dbg_ack),
    .o_sram_waddr(waddr), .o_sram_wdata(wdata), .o_sram_wen(wen),
    .o_sram_raddr(raddr), .o_sram_ren(ren), .i_sram_rdata(rdata)
  );

  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

  typedef struct {
    logic        dbg;
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rdt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic cyc);
    if (v.dbg) begin
      dbg_adr = v.adr; dbg_dat = v.dat; dbg_sel = v.sel; dbg_we = v.we; dbg_cyc = cyc;
    end else begin
      cpu_adr = v.adr; cpu_dat = v.dat; cpu_sel = v.sel; cpu_we = v.we; cpu_cyc = cyc;
    end
  endtask

  // One transaction: byte strobes per cycle, ack latency, ack exclusivity, read data.
  task automatic run_xfer(input vec_t v);
    vec_t junk;
    int   lat;
    @(negedge clk);
    drive(v, 1'b1);
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 4) begin
        chk("wen_byte", {31'b0, wen}, {31'b0, v.we & v.sel[i]});
        chk("ren_byte", {31'b0, ren}, {31'b0, ~v.we});
        if (v.we && v.sel[i]) begin
          chk("waddr", {24'b0, waddr}, {24'b0, v.adr[7:2], 2'(i)});
          chk("wdata", {24'b0, wdata}, {24'b0, v.dat[8*i +: 8]});
        end
      end else if (i == 4) begin
        chk("done_idle_enables", {31'b0, wen | ren}, 32'd0);
      end
      if (cpu_ack || dbg_ack) begin
        lat = i;
        break;
      end
      if (i == 0) begin
        // Scramble the master's inputs once granted; the latched copy must be used.
        junk = v;
        junk.adr = ~v.adr; junk.dat = ~v.dat; junk.sel = ~v.sel; junk.we = ~v.we;
        drive(junk, 1'b1);
      end
    end
    chk("ack_latency", 32'(lat), 32'd5);
    chk("cpu_ack", {31'b0, cpu_ack}, {31'b0, ~v.dbg & (lat >= 0)});
    chk("dbg_ack", {31'b0, dbg_ack}, {31'b0, v.dbg & (lat >= 0)});
    if (!v.we) chk("rdt", v.dbg ? dbg_rdt : cpu_rdt, v.exp_rdt);
    drive(v, 1'b0);
    @(negedge clk);
    chk("ack_one_cycle", {30'b0, cpu_ack, dbg_ack}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_cyc = 1'b0;
    dbg_cyc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [11];
  vec_t rv;
  logic exp_order [3];
  logic who;
  int   nack, last_t;
  logic raise_cpu, raise_dbg;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h10, 32'h11223344, 4'b1111, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 8'h10, 32'h0,        4'b0000, 32'h11223344};
    tbl[2]  = '{1'b1, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 8'h20, 32'h0,        4'b0000, 32'h00BB00DD};
    tbl[4]  = '{1'b0, 1'b1, 8'h40, 32'hDEADBEEF, 4'b0000, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 8'h40, 32'h0,        4'b0000, 32'h00000000};
    tbl[6]  = '{1'b1, 1'b1, 8'h13, 32'h55667788, 4'b1000, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 8'h11, 32'h0,        4'b0000, 32'h55223344};
    tbl[8]  = '{1'b0, 1'b1, 8'hFC, 32'h01020304, 4'b1111, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 8'hFF, 32'h0,        4'b0000, 32'h01020304};
    tbl[10] = '{1'b0, 1'b0, 8'h20, 32'h0,        4'b0000, 32'h00BB00DD};

    // Reset state and idle behaviour
    repeat (3) @(negedge clk);
    chk("rst_ack", {30'b0, cpu_ack, dbg_ack}, 32'd0);
    chk("rst_en", {30'b0, wen, ren}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_en", {30'b0, wen, ren}, 32'd0);
      chk("idle_ack", {30'b0, cpu_ack, dbg_ack}, 32'd0);
    end
    chk("idle_cpu_rdt", cpu_rdt, 32'd0);
    chk("idle_dbg_rdt", dbg_rdt, 32'd0);

    foreach (tbl[k]) run_xfer(tbl[k]);

    // Reset in the middle of a transfer (cnt = 2)
    rv = '{1'b0, 1'b0, 8'h10, 32'h0, 4'b0000, 32'h55223344};
    @(negedge clk);
    drive(rv, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_ren", {31'b0, ren}, 32'd1);
    chk("pre_rst_raddr", {24'b0, raddr}, 32'h12);
    rst_n = 1'b0;
    #1;
    chk("midrst_en", {30'b0, wen, ren}, 32'd0);
    chk("midrst_ack", {30'b0, cpu_ack, dbg_ack}, 32'd0);
    chk("midrst_rdt", cpu_rdt, 32'd0);
    cpu_cyc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      chk("post_rst_ack", {30'b0, cpu_ack, dbg_ack}, 32'd0);
      chk("post_rst_en", {30'b0, wen, ren}, 32'd0);
    end
    run_xfer(rv);

    // Both masters contend from reset: CPU, DBG, CPU
    do_reset();
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
    @(negedge clk);
    drive('{1'b0, 1'b0, 8'h10, 32'h0, 4'b0000, 32'h0}, 1'b1);
    drive('{1'b1, 1'b0, 8'h20, 32'h0, 4'b0000, 32'h0}, 1'b1);
    nack = 0; last_t = -1; raise_cpu = 1'b0; raise_dbg = 1'b0;
    for (int t = 0; t < 60 && nack < 3; t++) begin
      @(negedge clk);
      if (raise_cpu) cpu_cyc = 1'b1;
      if (raise_dbg) dbg_cyc = 1'b1;
      raise_cpu = 1'b0; raise_dbg = 1'b0;
      chk("ack_overlap", {31'b0, cpu_ack & dbg_ack}, 32'd0);
      if (cpu_ack || dbg_ack) begin
        who = dbg_ack;
        chk("rr_order", {31'b0, who}, {31'b0, exp_order[nack]});
        chk("rr_rdt", who ? dbg_rdt : cpu_rdt, who ? 32'h00BB00DD : 32'h55223344);
        if (nack == 0) chk("rr_first_lat", 32'(t), 32'd5);
        else           chk("rr_gap", 32'(t - last_t), 32'd7);
        last_t = t;
        if (who) begin dbg_cyc = 1'b0; raise_dbg = 1'b1; end
        else     begin cpu_cyc = 1'b0; raise_cpu = 1'b1; end
        nack++;
      end
    end
    chk("rr_ack_count", 32'(nack), 32'd3);
    cpu_cyc = 1'b0;
    dbg_cyc = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
